tow_round_controller: RTL and testbench



---
 rtl/tow_round_controller_if.sv | 16 +
 rtl/tow_round_controller.sv | 97 +++++++++
 tb/tb_tow_round_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/tow_round_controller_if.sv
// tow_round_controller_if: press/restart inputs and lamp/score outputs of the tug-of-war referee
interface tow_round_controller_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W = 3
);
  logic l_press;
  logic r_press;
  logic restart;
  logic [NUM_LIGHTS-1:0] lights;
  logic [1:0] winner;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic game_over;
  modport master (output l_press, r_press, restart, input lights, winner, score_l, score_r, game_over);
  modport slave (input l_press, r_press, restart, output lights, winner, score_l, score_r, game_over);
endinterface

// File: rtl/tow_round_controller.sv
// tow_round_controller: tug-of-war referee (light, points, hold, game over); TOW_LOCKOUT_EN adds per-player press lockout
module tow_round_controller #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W = 3,
  parameter int HOLD_CYCLES = 50000000,
  parameter int LOCKOUT_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  tow_round_controller_if.slave bus
);
  localparam int C = (NUM_LIGHTS - 1) / 2;
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [NUM_LIGHTS-1:0] CENTER = NUM_LIGHTS'(1) << C;
  localparam logic [SCORE_W-1:0] MAX = '1;
  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;
  if (NUM_LIGHTS < 3 || NUM_LIGHTS % 2 == 0 || HOLD_CYCLES < 1 || LOCKOUT_CYCLES < 0) begin : g_bad_params
    $error("tow_round_controller: illegal parameter set");
  end
  state_t r_state;
  logic [HW-1:0] r_hold;
  logic [NUM_LIGHTS-1:0] r_lights;
  logic [1:0] r_winner;
  logic [SCORE_W-1:0] r_score_l;
  logic [SCORE_W-1:0] r_score_r;
  logic r_game_over;
  logic w_l;
  logic w_r;
  assign bus.lights = r_lights;
  assign bus.winner = r_winner;
  assign bus.score_l = r_score_l;
  assign bus.score_r = r_score_r;
  assign bus.game_over = r_game_over;
`ifdef TOW_LOCKOUT_EN
  localparam int LW = LOCKOUT_CYCLES > 0 ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  logic [LW-1:0] r_lock_l;
  logic [LW-1:0] r_lock_r;
  assign w_l = bus.l_press && r_lock_l == '0;
  assign w_r = bus.r_press && r_lock_r == '0;
  // lockout windows: armed by an accepted solo press in PLAY, cleared whenever a fresh round starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.restart || (r_state == HOLD && r_hold == '0)) begin
      r_lock_l <= '0;
      r_lock_r <= '0;
    end else begin
      r_lock_l <= (r_state == PLAY && w_l && !w_r) ? LW'(LOCKOUT_CYCLES) : (r_lock_l != '0) ? r_lock_l - LW'(1) : '0;
      r_lock_r <= (r_state == PLAY && w_r && !w_l) ? LW'(LOCKOUT_CYCLES) : (r_lock_r != '0) ? r_lock_r - LW'(1) : '0;
    end
  end
`else
  assign w_l = bus.l_press;
  assign w_r = bus.r_press;
`endif
  // round FSM: moves the lamp, scores points at the ends, times the hold and freezes at game over
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.restart) begin
      r_state <= PLAY;
      r_hold <= '0;
      r_lights <= CENTER;
      r_winner <= 2'b00;
      r_score_l <= '0;
      r_score_r <= '0;
      r_game_over <= 1'b0;
    end else if (r_state == PLAY) begin
      if (w_l && !w_r) begin
        if (r_lights[NUM_LIGHTS-1]) begin
          r_score_l <= (r_score_l == MAX) ? MAX : r_score_l + SCORE_W'(1);
          r_winner <= 2'b01;
          r_hold <= HW'(HOLD_CYCLES - 1);
          r_state <= HOLD;
        end else begin
          r_lights <= r_lights << 1;
        end
      end else if (w_r && !w_l) begin
        if (r_lights[0]) begin
          r_score_r <= (r_score_r == MAX) ? MAX : r_score_r + SCORE_W'(1);
          r_winner <= 2'b10;
          r_hold <= HW'(HOLD_CYCLES - 1);
          r_state <= HOLD;
        end else begin
          r_lights <= r_lights >> 1;
        end
      end
    end else if (r_state == HOLD) begin
      if (r_hold != '0) begin
        r_hold <= r_hold - HW'(1);
      end else if (r_score_l == MAX || r_score_r == MAX) begin
        r_state <= OVER;
        r_game_over <= 1'b1;
      end else begin
        r_state <= PLAY;
        r_lights <= CENTER;
        r_winner <= 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_tow_round_controller.sv
// tb_tow_round_controller: directed tug-of-war vectors checked every cycle against a behavioural referee model
module tb_tow_round_controller;
  localparam int N = 9, SW = 2, H = 8, L = 4, C = 4, MAX = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  tow_round_controller_if #(.NUM_LIGHTS(N), .SCORE_W(SW)) bus ();
  tow_round_controller #(.NUM_LIGHTS(N), .SCORE_W(SW), .HOLD_CYCLES(H), .LOCKOUT_CYCLES(L)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;

  // referee model: phase 0 = play, 1 = hold (m_hold cycles left), 2 = game over
  int m_pos, m_sl, m_sr, m_win, m_phase, m_hold;
  int m_cyc = 0;
  int m_last_l = -100;
  int m_last_r = -100;
  logic m_l, m_r;
`ifdef TOW_LOCKOUT_EN
  assign m_l = bus.l_press && (m_cyc - m_last_l > L);
  assign m_r = bus.r_press && (m_cyc - m_last_r > L);
`else
  assign m_l = bus.l_press;
  assign m_r = bus.r_press;
`endif
  always @(posedge clk or posedge reset) begin
    if (reset || bus.restart) begin
      m_pos <= C; m_sl <= 0; m_sr <= 0; m_win <= 0; m_phase <= 0; m_hold <= 0;
      m_last_l <= -100; m_last_r <= -100;
      if (!reset) m_cyc <= m_cyc + 1;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_phase == 0) begin
        if (m_l && !m_r) begin
          m_last_l <= m_cyc;
          if (m_pos == N - 1) begin
            m_sl <= (m_sl == MAX) ? MAX : m_sl + 1; m_win <= 1; m_phase <= 1; m_hold <= H;
          end else m_pos <= m_pos + 1;
        end else if (m_r && !m_l) begin
          m_last_r <= m_cyc;
          if (m_pos == 0) begin
            m_sr <= (m_sr == MAX) ? MAX : m_sr + 1; m_win <= 2; m_phase <= 1; m_hold <= H;
          end else m_pos <= m_pos - 1;
        end
      end else if (m_phase == 1) begin
        if (m_hold > 1) m_hold <= m_hold - 1;
        else if (m_sl == MAX || m_sr == MAX) m_phase <= 2;
        else begin
          m_phase <= 0; m_pos <= C; m_win <= 0; m_last_l <= -100; m_last_r <= -100;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("lights", 32'(bus.lights), 32'(1) << m_pos);
    chk("winner", 32'(bus.winner), m_win);
    chk("score_l", 32'(bus.score_l), m_sl);
    chk("score_r", 32'(bus.score_r), m_sr);
    chk("game_over", 32'(bus.game_over), 32'(m_phase == 2));
  endtask

  task automatic step(input bit l, input bit r, input bit rs);
    bus.l_press = l;
    bus.r_press = r;
    bus.restart = rs;
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic press(input bit l, input bit r);
    step(l, r, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic point_left();
    repeat (4) press(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bus.l_press = 1'b0;
    bus.r_press = 1'b0;
    bus.restart = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_lights", 32'(bus.lights), 32'h10);
    chk("rst_winner", 32'(bus.winner), 0);
    chk("rst_scores", {bus.score_l, bus.score_r}, 0);
    chk("rst_game_over", 32'(bus.game_over), 0);
    #10 reset = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0);
    chk("idle_lights", 32'(bus.lights), 32'h10);
    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0);
      chk("walk_left", 32'(bus.lights), 32'(1) << (5 + i));
    end
    for (int i = 0; i < 2; i++) begin
      press(1'b0, 1'b1);
      chk("walk_right", 32'(bus.lights), 32'(1) << (6 - i));
    end
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    chk("cancel_lights", 32'(bus.lights), 32'h10);
    chk("cancel_scores", {bus.score_l, bus.score_r}, 0);
    point_left();
    chk("point_score_l", 32'(bus.score_l), 1);
    chk("point_winner", 32'(bus.winner), 1);
    chk("point_lights", 32'(bus.lights), 32'h100);
    for (int i = 0; i < 7; i++) step(i[0], !i[0], 1'b0);
    chk("hold_lights", 32'(bus.lights), 32'h100);
    step(1'b0, 1'b1, 1'b0);
    chk("recenter_lights", 32'(bus.lights), 32'h10);
    chk("recenter_winner", 32'(bus.winner), 0);
    point_left();
    repeat (3) step(1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("midhold_rst_lights", 32'(bus.lights), 32'h10);
    chk("midhold_rst_winner", 32'(bus.winner), 0);
    chk("midhold_rst_score_l", 32'(bus.score_l), 0);
    #2 reset = 1'b0;
    for (int p = 0; p < 3; p++) begin
      point_left();
      repeat (8) step(1'b1, 1'b0, 1'b0);
    end
    chk("over_flag", 32'(bus.game_over), 1);
    chk("over_winner", 32'(bus.winner), 1);
    chk("over_score_l", 32'(bus.score_l), 3);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("frozen_lights", 32'(bus.lights), 32'h100);
    chk("frozen_score_l", 32'(bus.score_l), 3);
    step(1'b1, 1'b0, 1'b1);
    chk("restart_lights", 32'(bus.lights), 32'h10);
    chk("restart_scores", {bus.score_l, bus.score_r}, 0);
    chk("restart_game_over", 32'(bus.game_over), 0);
    repeat (4) press(1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("right_point_score_r", 32'(bus.score_r), 1);
    chk("right_point_winner", 32'(bus.winner), 2);
    chk("right_point_lights", 32'(bus.lights), 32'h1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("lock_c0", 32'(bus.lights), 32'h20);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
`ifdef TOW_LOCKOUT_EN
    chk("lock_c2", 32'(bus.lights), 32'h20);
`else
    chk("lock_c2", 32'(bus.lights), 32'h40);
`endif
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
`ifdef TOW_LOCKOUT_EN
    chk("lock_c5", 32'(bus.lights), 32'h40);
    step(1'b1, 1'b1, 1'b0);
    chk("lock_both", 32'(bus.lights), 32'h20);
`else
    chk("lock_c5", 32'(bus.lights), 32'h80);
    step(1'b1, 1'b1, 1'b0);
    chk("lock_both", 32'(bus.lights), 32'h80);
`endif
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 149) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
